// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Frame: HEADER, N, 2N payload bytes (high byte first), XOR checksum.
package program_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;
   localparam int LEN_W  = 8;

   localparam logic [BYTE_W-1:0] HEADER_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
      ST_CHK  = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_e;

   function automatic logic in_frame(input state_e s);
      return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/program_loader_timeout.sv
// Clearable saturating idle counter; expire_o flags TIMEOUT-1 idle cycles
// while run_i is high. Requires TIMEOUT >= 2.
module program_loader_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic clock,
   input  logic reset_n,
   input  logic run_i,
   input  logic clear_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !run_i) begin
         cnt_d = '0;
      end else if (cnt_q != LAST) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream into instruction memory and releases the
// processor (cpu_run) only after a complete frame with a good checksum.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int                ADDR_W  = 8,
   parameter int                TIMEOUT = 1024,
   parameter logic [BYTE_W-1:0] HEADER  = HEADER_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic [ADDR_W:0]   words_loaded,
   output logic              cpu_run,
   output logic              load_done,
   output logic              load_err
);

   localparam int MAX_WORDS = 1 << ADDR_W;

   state_e              state_q;
   logic                rdy_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [WORD_W-1:0]   wdata_q;
   logic [ADDR_W:0]     words_q;
   logic [LEN_W-1:0]    len_q;
   logic [BYTE_W-1:0]   hi_q;
   logic [BYTE_W-1:0]   chk_q;
   logic                run_q;

   logic                accept;
   logic                tmo_expire;
   logic                last_word;

   assign accept    = rx_valid && rdy_q;
   assign last_word = (int'(words_q) + 1) == int'(len_q);

   program_loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock    (clock),
      .reset_n  (reset_n),
      .run_i    (in_frame(state_q)),
      .clear_i  (accept),
      .expire_o (tmo_expire)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         rdy_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         words_q <= '0;
         len_q   <= '0;
         hi_q    <= '0;
         chk_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         we_q  <= 1'b0;
         // cpu_run trails DONE by one cycle; a restart from DONE overrides it below
         run_q <= (state_q == ST_DONE);
         if (accept) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (rx_data == HEADER) begin
                     state_q <= ST_LEN;
                     words_q <= '0;
                     chk_q   <= '0;
                  end
               end
               ST_LEN: begin
                  len_q <= rx_data;
                  if (rx_data == '0 || int'(rx_data) > MAX_WORDS) begin
                     state_q <= ST_ERR;
                  end else begin
                     state_q <= ST_HI;
                  end
               end
               ST_HI: begin
                  hi_q    <= rx_data;
                  chk_q   <= chk_q ^ rx_data;
                  state_q <= ST_LO;
               end
               ST_LO: begin
                  chk_q   <= chk_q ^ rx_data;
                  we_q    <= 1'b1;
                  addr_q  <= words_q[ADDR_W-1:0];
                  wdata_q <= {hi_q, rx_data};
                  words_q <= words_q + 1'b1;
                  state_q <= last_word ? ST_CHK : ST_HI;
               end
               ST_CHK: begin
                  state_q <= (rx_data == chk_q) ? ST_DONE : ST_ERR;
               end
               ST_DONE, ST_ERR: begin
                  if (rx_data == HEADER) begin
                     state_q <= ST_LEN;
                     words_q <= '0;
                     chk_q   <= '0;
                     run_q   <= 1'b0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (tmo_expire) begin
            state_q <= ST_ERR;
         end
      end
   end

   assign rx_ready     = rdy_q;
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign words_loaded = words_q;
   assign cpu_run      = run_q;
   assign load_done    = (state_q == ST_DONE);
   assign load_err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader with a write scoreboard.
module tb_program_loader;

   logic        clock;
   logic        reset_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [1:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic [2:0]  words_loaded;
   logic        cpu_run;
   logic        load_done;
   logic        load_err;

   program_loader #(
      .ADDR_W  (2),
      .TIMEOUT (16),
      .HEADER  (8'hA5)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .words_loaded (words_loaded),
      .cpu_run      (cpu_run),
      .load_done    (load_done),
      .load_err     (load_err)
   );

   typedef struct {
      logic [1:0]  addr;
      logic [15:0] data;
      int          cyc;
   } wr_t;

   wr_t sbq[$];
   wr_t e;
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic r, input logic d, input logic er,
                         input logic c, input logic [2:0] w);
      chk({tag, ".rx_ready"}, 32'(rx_ready), 32'(r));
      chk({tag, ".load_done"}, 32'(load_done), 32'(d));
      chk({tag, ".load_err"}, 32'(load_err), 32'(er));
      chk({tag, ".cpu_run"}, 32'(cpu_run), 32'(c));
      chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(w));
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask

   // Called right after the low byte: the pulse is due in the following cycle.
   task automatic exp_wr(input logic [1:0] a, input logic [15:0] d);
      sbq.push_back('{addr: a, data: d, cyc: cyc});
   endtask

   always @(negedge clock) begin
      if (reset_n && imem_we) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0h data=%0h", imem_addr, imem_wdata);
         end else begin
            e = sbq.pop_front();
            if (imem_addr !== e.addr || imem_wdata !== e.data || cyc != e.cyc ||
                words_loaded !== ({1'b0, e.addr} + 3'd1)) begin
               errors++;
               $display("FAIL write actual addr=%0h data=%0h cyc=%0d words=%0d expected addr=%0h data=%0h cyc=%0d words=%0d",
                        imem_addr, imem_wdata, cyc, words_loaded, e.addr, e.data, e.cyc,
                        {1'b0, e.addr} + 3'd1);
            end
         end
      end
   end

   initial begin
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      reset_n  = 1'b1;
      #1 reset_n = 1'b0;
      #3;
      chk_st("reset", 0, 0, 0, 0, 0);
      chk("reset.imem_we", 32'(imem_we), 0);
      @(posedge clock);
      #1;
      chk("reset_hold.rx_ready", 32'(rx_ready), 0);
      #12 reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk_st("release", 1, 0, 0, 0, 0);

      // Noise, then nominal load
      send_byte(8'h00);
      send_byte(8'hFF);
      chk_st("noise", 1, 0, 0, 0, 0);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34); exp_wr(2'd0, 16'h1234);
      send_byte(8'hAB);
      send_byte(8'hCD); exp_wr(2'd1, 16'hABCD);
      send_byte(8'h40);
      chk_st("nominal_done", 1, 1, 0, 0, 2);
      @(posedge clock);
      #1;
      chk("nominal_cpu_run", 32'(cpu_run), 1);

      // Restart from DONE, then bad checksum
      send_byte(8'hA5);
      chk_st("restart", 1, 0, 0, 0, 0);
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34); exp_wr(2'd0, 16'h1234);
      send_byte(8'hAB);
      send_byte(8'hCD); exp_wr(2'd1, 16'hABCD);
      send_byte(8'h41);
      chk_st("badchk", 1, 0, 1, 0, 2);
      @(posedge clock);
      #1;
      chk("badchk_cpu_run", 32'(cpu_run), 0);
      send_byte(8'h12);
      chk("err_ignore.load_err", 32'(load_err), 1);

      // Length errors and full-size boundary
      send_byte(8'hA5);
      chk("err_restart.load_err", 32'(load_err), 0);
      send_byte(8'h00);
      chk_st("len_zero", 1, 0, 1, 0, 0);
      send_byte(8'hA5);
      send_byte(8'h05);
      chk_st("len_big", 1, 0, 1, 0, 0);
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h01); send_byte(8'h02); exp_wr(2'd0, 16'h0102);
      send_byte(8'h03); send_byte(8'h04); exp_wr(2'd1, 16'h0304);
      send_byte(8'h05); send_byte(8'h06); exp_wr(2'd2, 16'h0506);
      send_byte(8'h07); send_byte(8'h80); exp_wr(2'd3, 16'h0780);
      send_byte(8'h80);
      chk_st("len_max", 1, 1, 0, 0, 4);

      // Timeout expiry in LO
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h12);
      repeat (15) @(posedge clock);
      #1;
      chk("tmo_before.load_err", 32'(load_err), 0);
      @(posedge clock);
      #1;
      chk_st("tmo_expired", 1, 0, 1, 0, 0);

      // Byte arriving on the expiry cycle wins
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h12);
      repeat (15) @(posedge clock);
      #1;
      send_byte(8'h34); exp_wr(2'd0, 16'h1234);
      chk("tmo_race.load_err", 32'(load_err), 0);
      send_byte(8'h26);
      chk_st("tmo_race_done", 1, 1, 0, 0, 1);

      // Asynchronous reset while in LO with a byte pending
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h12);
      rx_valid = 1'b1;
      rx_data  = 8'h34;
      #2 reset_n = 1'b0;
      #1;
      chk_st("async_rst", 0, 0, 0, 0, 0);
      chk("async_rst.imem_wdata", 32'(imem_wdata), 0);
      chk("async_rst.imem_we", 32'(imem_we), 0);
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
      chk("async_hold.rx_ready", 32'(rx_ready), 0);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk_st("async_release", 1, 0, 0, 0, 0);
      send_byte(8'h34);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'hAB);
      send_byte(8'hCD); exp_wr(2'd0, 16'hABCD);
      send_byte(8'h66);
      chk_st("post_reset_load", 1, 1, 0, 0, 1);

      repeat (3) @(posedge clock);
      #1;
      chk("scoreboard_empty", 32'(sbq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time block directly upstream of the 16-bit pipelined processor.
- Receives a framed byte stream, assembles 16-bit instruction words, and writes them into instruction memory.
- Holds the processor out of execution (cpu_run low) until a complete frame has been loaded and its checksum verified.
- Frame format: header 0xA5, length N (number of words, 1..255), then 2N payload bytes (high byte first), then a checksum byte equal to the XOR of all payload bytes.

Parameters:
ADDR_W, 8, instruction-memory word-address width; N greater than 2^ADDR_W is an error.
TIMEOUT, 1024, maximum idle clock cycles between bytes inside a frame before aborting.
HEADER, 8'hA5, frame start byte.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
rx_valid  input  1  byte available on rx_data.
rx_data  input  8  incoming byte.
rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid and rx_ready are both high.
imem_we  output  1  instruction-memory write strobe, one-cycle pulse.
imem_addr  output  ADDR_W  word address for the write.
imem_wdata  output  16  instruction word {hi, lo}.
words_loaded  output  ADDR_W+1  count of words written in the current frame.
cpu_run  output  1  processor enable (high = processor executes).
load_done  output  1  high while in DONE.
load_err  output  1  high while in ERR.

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low; clock port is `clock`, reset port is `reset_n`.
- Reset values: all outputs 0, state IDLE, counters 0. rx_ready stays 0 while reset_n is low and goes to 1 on the first clock edge after release.
- States: IDLE, LEN, HI, LO, CHK, DONE, ERR. All state changes happen only on an accepted byte or on timeout.
- IDLE: a byte equal to HEADER moves to LEN; clears words_loaded and the checksum accumulator. Other bytes are discarded.
- LEN: stores N.
  - N == 0 → ERR.
  - N > 2^ADDR_W → ERR.
  - Otherwise → HI.
- HI: latches the high byte, XORs it into the checksum → LO.
- LO: XORs the low byte into the checksum.
  - Next cycle: imem_we=1, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata={hi, lo}. Write latency is 1 cycle after the low byte transfers.
  - words_loaded increments in the same cycle the write is issued.
  - Next state: CHK if this was word N, otherwise HI.
- CHK: byte equal to the accumulator → DONE; any other value → ERR.
- DONE: load_done=1; cpu_run=1 from the cycle after DONE is entered.
- ERR: load_err=1, cpu_run=0.
- DONE or ERR receiving HEADER: restarts the load (go to LEN, counters cleared). cpu_run, load_done and load_err all drop on the same edge.
- DONE or ERR receiving any other byte: byte is accepted and ignored.
- rx_ready: 1 in every state. Backpressure is not required because each write completes in one cycle.
- Timeout counter:
  - Runs only in LEN, HI, LO and CHK.
  - Clears on every accepted byte and on entry to any of those states.
  - Reaching TIMEOUT-1 → ERR.
  - If a byte is accepted in the same cycle the timeout expires, the byte wins and the counter clears.
- Reset mid-frame: immediate return to IDLE with cpu_run=0; a partially written memory image is left in place and is not cleared.
- Checksum arithmetic: 8-bit XOR, no carry. words_loaded is ADDR_W+1 bits so that a full 2^ADDR_W load is representable.

Decomposition:
- Shared package: state enum (IDLE..ERR), HEADER constant, frame-field widths.
- Natural sub-module: loader_timeout, a clearable saturating counter with an expire output.
- The FSM and datapath stay in program_loader.

Test Plan:
- Nominal load: A5 02 12 34 AB CD 40 → writes (0, 0x1234) then (1, 0xABCD); each imem_we pulse comes 1 cycle after its low byte; DONE reached; cpu_run=1 one cycle later; words_loaded=2.
- Bad checksum: same frame with checksum 41 → no change to the writes; ERR entered; load_err=1; cpu_run stays 0.
- Length errors: A5 00 → ERR. With ADDR_W=2, A5 05 → ERR, and no imem_we pulse in either case.
- Timeout: A5 01 12, then silence for TIMEOUT cycles → ERR on cycle TIMEOUT-1. Repeat with a byte arriving exactly on that cycle → HI/LO path continues with no error.
- Restart and noise: leading noise bytes 00 FF, then a valid frame, then A5 in DONE → cpu_run drops on that edge; a second frame loads from address 0.
- Async reset: assert reset_n low during LO with rx_valid=1 → all outputs 0 immediately; after release, rx_ready=1 and the state is IDLE.
